seq_pipe_add2_join: RTL
=======================

# seq_pipe_add2_join

Upstream operand-join stage for the 8-bit two-input pipelined adder. It accepts two independent val/rdy operand streams and buffers each in its own small FIFO. It presents matched operand pairs (head of stream 0, head of stream 1) to the adder's in0/in1 inputs together with a pair-valid flag. The adder registers whatever it sees every cycle, so the join drives zeros whenever no pair is valid.

## Interface
- DEPTH, 2, entries per operand FIFO; power of two, ≥ 2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in0_val  input  1  operand-0 producer has valid data
- in0_rdy  output  1  join can accept operand 0
- in0  input  8  operand-0 data
- in1_val  input  1  operand-1 producer has valid data
- in1_rdy  output  1  join can accept operand 1
- in1  input  8  operand-1 data
- out_val  output  1  a matched pair is presented
- out_rdy  input  1  consumer takes the pair; tied high when driving the adder directly
- out0  output  8  operand 0 of the pair; feeds adder in0
- out1  output  8  operand 1 of the pair; feeds adder in1
- pairs  output  16  count of pairs transferred since reset

## Operation
- Two identical circular FIFOs, one per channel:
  - DEPTH × 8-bit storage.
  - Read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits.
- inN_rdy = (countN != DEPTH). Depends only on the FIFO's own full state; never on out_rdy or the other channel.
- Enqueue N when inN_val && inN_rdy: write inN at wptrN, increment wptrN, increment countN.
- out_val = (count0 != 0) && (count1 != 0).
- out0/out1 = storage heads at rptr0/rptr1 when out_val = 1; both exactly 8'h00 when out_val = 0.
- Dequeue when out_val && out_rdy: increment both rptrs, decrement both counts, increment pairs. pairs wraps 16'hFFFF → 0.
- Simultaneous enqueue and dequeue on one FIFO: count unchanged, both pointers advance.
- No bypass: data enqueued in an empty FIFO becomes visible only in the next cycle.
- One channel running ahead of the other is legal. That FIFO fills, its rdy drops, and it holds until the lagging channel supplies data.
- Data never combines across pairs. The k-th accepted in0 is always paired with the k-th accepted in1.
- Transfers with val = 0 are ignored. Data bits are don't-care when val = 0.

## Timing
- Reset (sampled high at posedge):
  - Both FIFOs empty, pointers 0, pairs = 0.
  - Outputs from the next cycle: in0_rdy = in1_rdy = 1, out_val = 0, out0 = out1 = 0.
- Reset mid-operation discards all buffered operands; no pair is emitted for them.
- Reset takes priority over a simultaneous enqueue or dequeue in the same cycle.
- Latency: both operands accepted at edge t → out_val = 1 and out0/out1 valid during cycle t+1. The adder sum appears one cycle after that.
- Throughput: one pair per cycle with out_rdy held high and both producers streaming. Steady-state occupancy is 1, so rdy stays high.
- out_rdy low with out_val high: pair held stable; FIFOs may fill to DEPTH, then inN_rdy = 0.
- All outputs are functions of registered state only; no combinational input-to-output path.

## Test plan
- Reset then idle: reset high 2 cycles, low 3 cycles → in0_rdy = in1_rdy = 1, out_val = 0, out0 = out1 = 0, pairs = 0 throughout.
- Single pair: in0 = 8'h12 and in1 = 8'h34, both valid for one cycle with out_rdy = 1 → next cycle out_val = 1, out0 = 12, out1 = 34. Following cycle out_val = 0, pairs = 1. The adder then shows out = 8'h46.
- Skewed arrival: in0 sends 8'h01, 8'h02, 8'h03 on consecutive cycles while in1 is idle → after 2 accepts in0_rdy = 0; the third value is held off, and out_val stays 0. in1 then sends 8'h10, 8'h20 → pairs (01,10), (02,20) appear in order, then (03, next in1).
- Backpressure: both FIFOs full, out_rdy = 0 for 4 cycles → out0/out1 stable, rdys 0. out_rdy = 1 → 2 pairs drain on consecutive cycles, in order, and rdys return to 1.
- Wrap-around: stream 300 random pairs with random val gaps and random out_rdy → output pair sequence matches a scoreboard exactly; pairs = 300 (16'h012C); pointer wrap causes no loss or duplication.
- Reset mid-stream: one FIFO holds 2 entries and the other 1; assert reset for one cycle → out_val = 0, pairs = 0, both rdy = 1. A new pair (8'hAA, 8'h55) is then output as the first pair.

Source files
------------

// File: rtl/seq_pipe_add2_join_if.sv
// Operand-join bus: two val/rdy operand producers, one paired-operand consumer
// and the running pair counter.
interface seq_pipe_add2_join_if;
    localparam int unsigned DW   = 8;
    localparam int unsigned CNTW = 16;

    logic            in0_val;
    logic            in0_rdy;
    logic [DW-1:0]   in0;
    logic            in1_val;
    logic            in1_rdy;
    logic [DW-1:0]   in1;
    logic            out_val;
    logic            out_rdy;
    logic [DW-1:0]   out0;
    logic [DW-1:0]   out1;
    logic [CNTW-1:0] pairs;

    // Producer/consumer side (drives operands, accepts pairs)
    modport master (
        output in0_val, in0, in1_val, in1, out_rdy,
        input  in0_rdy, in1_rdy, out_val, out0, out1, pairs
    );

    // Join side
    modport slave (
        input  in0_val, in0, in1_val, in1, out_rdy,
        output in0_rdy, in1_rdy, out_val, out0, out1, pairs
    );
endinterface

// File: rtl/seq_pipe_add2_join.sv
// Operand-join stage ahead of the 8-bit pipelined adder: buffers each operand
// stream in its own circular FIFO and presents head-of-line pairs, driving
// zeros whenever no complete pair is available.

// Single-channel circular FIFO without bypass; head is read from storage.
module seq_pipe_add2_join_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_enq_val,
    input  logic [DW-1:0] i_enq_data,
    output logic          o_enq_rdy,
    input  logic          i_deq,
    output logic [DW-1:0] o_head,
    output logic          o_nonempty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_enq;

    // Ready depends only on this FIFO's own fullness
    assign o_enq_rdy  = (r_count != CW'(DEPTH));
    assign w_enq      = i_enq_val & o_enq_rdy;
    assign o_nonempty = (r_count != '0);
    assign o_head     = r_mem[r_rptr];

    // Operand storage; not reset since the occupancy count qualifies it
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_mem[r_wptr] <= i_enq_data;
        end
    end

    // Pointers and occupancy; reset wins over any same-cycle transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (i_deq) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_enq, i_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// Join top: pairs the k-th operand of each stream and counts transfers.
module seq_pipe_add2_join #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    seq_pipe_add2_join_if.slave bus
);
    localparam int unsigned DW   = 8;
    localparam int unsigned CNTW = 16;

    logic [DW-1:0]   w_head0;
    logic [DW-1:0]   w_head1;
    logic            w_ne0;
    logic            w_ne1;
    logic            w_out_val;
    logic            w_deq;
    logic            w_rdy0;
    logic            w_rdy1;
    logic [CNTW-1:0] r_pairs;

    // Both FIFOs pop together, so the pairing order can never drift
    assign w_out_val = w_ne0 & w_ne1;
    assign w_deq     = w_out_val & bus.out_rdy;

    seq_pipe_add2_join_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo0 (
        .clk        (clk),
        .reset      (reset),
        .i_enq_val  (bus.in0_val),
        .i_enq_data (bus.in0),
        .o_enq_rdy  (w_rdy0),
        .i_deq      (w_deq),
        .o_head     (w_head0),
        .o_nonempty (w_ne0)
    );

    seq_pipe_add2_join_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo1 (
        .clk        (clk),
        .reset      (reset),
        .i_enq_val  (bus.in1_val),
        .i_enq_data (bus.in1),
        .o_enq_rdy  (w_rdy1),
        .i_deq      (w_deq),
        .o_head     (w_head1),
        .o_nonempty (w_ne1)
    );

    // Count of completed pair transfers, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pairs <= '0;
        end else if (w_deq) begin
            r_pairs <= r_pairs + CNTW'(1);
        end
    end

    // The adder registers every cycle, so idle cycles must present zeros
    assign bus.in0_rdy = w_rdy0;
    assign bus.in1_rdy = w_rdy1;
    assign bus.out_val = w_out_val;
    assign bus.out0    = w_out_val ? w_head0 : '0;
    assign bus.out1    = w_out_val ? w_head1 : '0;
    assign bus.pairs   = r_pairs;
endmodule
